// File: rtl/vip_pkt_pkg.sv
// Shared packet-type codes, sequencer states and control-packet sizing for the VIP stream blocks.
package vip_pkt_pkg;

    localparam logic [3:0] PKT_TYPE_VIDEO = 4'h0;
    localparam logic [3:0] PKT_TYPE_CTRL  = 4'hF;

    // width, height and interlace nibbles: 4 + 4 + 1 symbols
    localparam int CTRL_PAYLOAD_SYMBOLS = 9;

    typedef enum logic [2:0] {
        IDLE,
        SEND_HDR,
        SEND_DATA,
        PASS,
        DROP
    } state_t;

    function automatic int ctrl_payload_beats(input int spb);
        return (CTRL_PAYLOAD_SYMBOLS + spb - 1) / spb;
    endfunction

endpackage

// File: rtl/vip_ctrl_packet_formatter.sv
// Combinational payload generator for the locally inserted control packet.
module vip_ctrl_packet_formatter
    import vip_pkt_pkg::*;
#(
    parameter  int BITS_PER_SYMBOL  = 8,
    parameter  int SYMBOLS_PER_BEAT = 3,
    localparam int BEAT_W           = $clog2(ctrl_payload_beats(SYMBOLS_PER_BEAT))
) (
    input  logic [BEAT_W-1:0]                          beat,
    input  logic [15:0]                                width,
    input  logic [15:0]                                height,
    input  logic [3:0]                                 interlaced,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] data,
    output logic                                       eop
);

    localparam int N_BEATS = ctrl_payload_beats(SYMBOLS_PER_BEAT);

    logic [4*CTRL_PAYLOAD_SYMBOLS-1:0] payload;
    logic [4*CTRL_PAYLOAD_SYMBOLS-1:0] shifted;

    // Symbol 0 sits in the lowest nibble; shifting past the end pads trailing symbols with zero.
    always_comb begin
        // NOTE: every output gets a default before any conditional assignment so no latch is inferred.
        data    = '0;
        payload = {interlaced,
                   height[3:0], height[7:4], height[11:8], height[15:12],
                   width[3:0],  width[7:4],  width[11:8],  width[15:12]};
        shifted = payload >> (4 * SYMBOLS_PER_BEAT * int'(beat));
        for (int i = 0; i < SYMBOLS_PER_BEAT; i++) begin
            data[i*BITS_PER_SYMBOL +: 4] = shifted[i*4 +: 4];
        end
        eop = (beat == BEAT_W'(N_BEATS - 1));
    end

endmodule

// File: rtl/vip_control_packet_inserter.sv
// Avalon-ST sequencer: drops/passes upstream packets and inserts a local control packet
// ahead of video packets whenever the configuration has changed (or always, if configured).
module vip_control_packet_inserter
    import vip_pkt_pkg::*;
#(
    parameter int BITS_PER_SYMBOL    = 8,
    parameter int SYMBOLS_PER_BEAT   = 3,
    parameter int INSERT_ALWAYS      = 0,
    parameter int DROP_UPSTREAM_CTRL = 1
) (
    input  logic                                       clk,
    input  logic                                       rst,
    output logic                                       din_ready,
    input  logic                                       din_valid,
    input  logic                                       din_sop,
    input  logic                                       din_eop,
    input  logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] din_data,
    input  logic                                       dout_ready,
    output logic                                       dout_valid,
    output logic                                       dout_sop,
    output logic                                       dout_eop,
    output logic [BITS_PER_SYMBOL*SYMBOLS_PER_BEAT-1:0] dout_data,
    input  logic                                       cfg_valid,
    input  logic [15:0]                                cfg_width,
    input  logic [15:0]                                cfg_height,
    input  logic [3:0]                                 cfg_interlaced,
    output logic                                       busy,
    output logic                                       ctrl_sent,
    output logic [15:0]                                ctrl_count
);

    localparam int DATA_W  = BITS_PER_SYMBOL * SYMBOLS_PER_BEAT;
    localparam int N_BEATS = ctrl_payload_beats(SYMBOLS_PER_BEAT);
    localparam int BEAT_W  = $clog2(N_BEATS);

    state_t            state;
    logic [BEAT_W-1:0] beat;
    logic              dirty;
    logic [15:0]       pend_w, pend_h, snap_w, snap_h;
    logic [3:0]        pend_i, snap_i;
    logic [DATA_W-1:0] fmt_data;
    logic              fmt_eop;
    logic [3:0]        in_type;
    logic              start_insert;

    assign in_type      = din_data[3:0];
    assign start_insert = (state == IDLE) && din_valid && din_sop && (in_type == PKT_TYPE_VIDEO)
                          && ((INSERT_ALWAYS != 0) || dirty);

    vip_ctrl_packet_formatter #(
        .BITS_PER_SYMBOL (BITS_PER_SYMBOL),
        .SYMBOLS_PER_BEAT(SYMBOLS_PER_BEAT)
    ) u_formatter (
        .beat      (beat),
        .width     (snap_w),
        .height    (snap_h),
        .interlaced(snap_i),
        .data      (fmt_data),
        .eop       (fmt_eop)
    );

    always_comb begin
        din_ready  = 1'b0;
        dout_valid = 1'b0;
        dout_sop   = 1'b0;
        dout_eop   = 1'b0;
        dout_data  = '0;
        unique case (state)
            IDLE:      din_ready = din_valid && !din_sop;
            SEND_HDR: begin
                dout_valid = 1'b1;
                dout_sop   = 1'b1;
                dout_data  = DATA_W'(PKT_TYPE_CTRL);
            end
            SEND_DATA: begin
                dout_valid = 1'b1;
                dout_eop   = fmt_eop;
                dout_data  = fmt_data;
            end
            PASS: begin
                din_ready  = dout_ready;
                dout_valid = din_valid;
                dout_sop   = din_sop;
                dout_eop   = din_eop;
                dout_data  = din_data;
            end
            DROP:      din_ready = 1'b1;
            default:   ;
        endcase
    end

    assign busy      = (state != IDLE);
    assign ctrl_sent = (state == SEND_DATA) && dout_ready && fmt_eop;

    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
        if (rst) begin
            state      <= IDLE;
            beat       <= '0;
            dirty      <= 1'b1;
            ctrl_count <= '0;
            pend_w     <= 16'd640;
            pend_h     <= 16'd480;
            pend_i     <= 4'h0;
        end else begin
            unique case (state)
                IDLE: if (din_valid && din_sop) begin
                    if (in_type == PKT_TYPE_CTRL && DROP_UPSTREAM_CTRL != 0) begin
                        state <= DROP;
                    end else if (start_insert) begin
                        state <= SEND_HDR;
                        dirty <= 1'b0;
                    end else begin
                        state <= PASS;
                    end
                end
                SEND_HDR: if (dout_ready) begin
                    state <= SEND_DATA;
                    beat  <= '0;
                end
                SEND_DATA: if (dout_ready) begin
                    if (fmt_eop) begin
                        state      <= PASS;
                        ctrl_count <= ctrl_count + 16'd1;
                    end else begin
                        beat <= beat + 1'b1;
                    end
                end
                PASS: if (din_valid && dout_ready && din_eop) state <= IDLE;
                DROP: if (din_valid && din_eop) state <= IDLE;
                default: state <= IDLE;
            endcase
            // Placed last so a same-cycle config update keeps dirty set over the insertion clear.
            if (cfg_valid) begin
                pend_w <= cfg_width;
                pend_h <= cfg_height;
                pend_i <= cfg_interlaced;
                dirty  <= 1'b1;
            end
        end
    end

    // NOTE: the snapshot is pure datapath, only read after being loaded, so it carries no reset.
    always_ff @(posedge clk) begin
        if (start_insert) begin
            snap_w <= pend_w;
            snap_h <= pend_h;
            snap_i <= pend_i;
        end
    end

endmodule

// File: tb/tb_vip_control_packet_inserter.sv
// Directed bench for vip_control_packet_inserter: SPB=3 main instance plus SPB=4/always-insert
// and SPB=1 instances for beat-count coverage.
module tb_vip_control_packet_inserter;

    typedef struct packed {
        logic        sop;
        logic        eop;
        logic [31:0] data;
    } beat_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst = 1'b1;

    // main instance, SPB=3, insert on change
    logic        din_ready;
    logic        din_valid = 1'b0;
    logic        din_sop = 1'b0;
    logic        din_eop = 1'b0;
    logic [23:0] din_data = '0;
    logic        dout_ready = 1'b1;
    logic        dout_valid, dout_sop, dout_eop;
    logic [23:0] dout_data;
    logic        cfg_valid = 1'b0;
    logic [15:0] cfg_width = '0;
    logic [15:0] cfg_height = '0;
    logic [3:0]  cfg_interlaced = '0;
    logic        busy, ctrl_sent;
    logic [15:0] ctrl_count;

    vip_control_packet_inserter #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(3), .INSERT_ALWAYS(0), .DROP_UPSTREAM_CTRL(1)
    ) dut (
        .clk(clk), .rst(rst),
        .din_ready(din_ready), .din_valid(din_valid), .din_sop(din_sop), .din_eop(din_eop),
        .din_data(din_data),
        .dout_ready(dout_ready), .dout_valid(dout_valid), .dout_sop(dout_sop), .dout_eop(dout_eop),
        .dout_data(dout_data),
        .cfg_valid(cfg_valid), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_interlaced(cfg_interlaced),
        .busy(busy), .ctrl_sent(ctrl_sent), .ctrl_count(ctrl_count)
    );

    // secondary instances: b = SPB=4 always-insert, c = SPB=1 insert on change
    logic        go_bc = 1'b0;
    logic        bc_ready = 1'b1;
    logic        bc_cfg_valid = 1'b0;
    logic        bc_one = 1'b1;
    int          pk_b = 0, pk_c = 0;
    logic        b_din_valid, c_din_valid;
    logic [31:0] b_din_data = '0;
    logic [7:0]  c_din_data = '0;
    logic        b_din_ready, b_dout_valid, b_dout_sop, b_dout_eop, b_busy, b_ctrl_sent;
    logic        c_din_ready, c_dout_valid, c_dout_sop, c_dout_eop, c_busy, c_ctrl_sent;
    logic [31:0] b_dout_data;
    logic [7:0]  c_dout_data;
    logic [15:0] b_ctrl_count, c_ctrl_count;

    assign b_din_valid = go_bc && (pk_b < 2);
    assign c_din_valid = go_bc && (pk_c < 2);
    always @(posedge clk) if (b_din_valid && b_din_ready) pk_b <= pk_b + 1;
    always @(posedge clk) if (c_din_valid && c_din_ready) pk_c <= pk_c + 1;

    vip_control_packet_inserter #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(4), .INSERT_ALWAYS(1), .DROP_UPSTREAM_CTRL(1)
    ) dut_b (
        .clk(clk), .rst(rst),
        .din_ready(b_din_ready), .din_valid(b_din_valid), .din_sop(bc_one), .din_eop(bc_one),
        .din_data(b_din_data),
        .dout_ready(bc_ready), .dout_valid(b_dout_valid), .dout_sop(b_dout_sop),
        .dout_eop(b_dout_eop), .dout_data(b_dout_data),
        .cfg_valid(bc_cfg_valid), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_interlaced(cfg_interlaced),
        .busy(b_busy), .ctrl_sent(b_ctrl_sent), .ctrl_count(b_ctrl_count)
    );

    vip_control_packet_inserter #(
        .BITS_PER_SYMBOL(8), .SYMBOLS_PER_BEAT(1), .INSERT_ALWAYS(0), .DROP_UPSTREAM_CTRL(1)
    ) dut_c (
        .clk(clk), .rst(rst),
        .din_ready(c_din_ready), .din_valid(c_din_valid), .din_sop(bc_one), .din_eop(bc_one),
        .din_data(c_din_data),
        .dout_ready(bc_ready), .dout_valid(c_dout_valid), .dout_sop(c_dout_sop),
        .dout_eop(c_dout_eop), .dout_data(c_dout_data),
        .cfg_valid(bc_cfg_valid), .cfg_width(cfg_width), .cfg_height(cfg_height),
        .cfg_interlaced(cfg_interlaced),
        .busy(c_busy), .ctrl_sent(c_ctrl_sent), .ctrl_count(c_ctrl_count)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    beat_t got_a[$], got_b[$], got_c[$], exp_q[$];
    int    valid_cycles_a = 0, rdy_cycles_a = 0, sent_a = 0;
    logic  stall_a = 1'b0;
    beat_t held_a;
    logic  rand_ready = 1'b0;

    // main-instance monitor: transfer capture, hold-while-stalled and ctrl_sent alignment
    always @(negedge clk) begin
        beat_t cur;
        cur = {dout_sop, dout_eop, 8'h00, dout_data};
        if (rst) begin
            stall_a = 1'b0;
        end else begin
            if (stall_a) check("hold_stable", 36'({dout_valid, cur}), 36'({1'b1, held_a}));
            if (dout_valid) valid_cycles_a++;
            if (din_valid && din_ready) rdy_cycles_a++;
            if (dout_valid && dout_ready) got_a.push_back(cur);
            if (ctrl_sent) begin
                sent_a++;
                check("ctrl_sent_on_eop", 36'({dout_valid, dout_ready, dout_eop}), 36'b111);
            end
            stall_a = dout_valid && !dout_ready;
            held_a  = cur;
        end
    end

    always @(negedge clk) begin
        if (!rst && b_dout_valid && bc_ready) got_b.push_back({b_dout_sop, b_dout_eop, b_dout_data});
        if (!rst && c_dout_valid && bc_ready) got_c.push_back({c_dout_sop, c_dout_eop, 24'h0, c_dout_data});
    end

    always @(posedge clk) begin
        #1;
        if (rand_ready) dout_ready = 1'($urandom_range(0, 1));
    end

    function automatic void e(input logic sop, input logic eop, input logic [31:0] data);
        exp_q.push_back({sop, eop, data});
    endfunction

    task automatic expect_beats(input string tag, input beat_t got[$]);
        check({tag, "_len"}, 36'(got.size()), 36'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got.size()) check($sformatf("%s_%0d", tag, i), 36'(got[i]), 36'(exp_q[i]));
        end
        exp_q.delete();
    endtask

    // starts and ends at posedge+1; holds the beat until the DUT accepts it
    task automatic drive_beat(input logic sop, input logic eop, input logic [23:0] data);
        int t = 0;
        din_valid = 1'b1;
        din_sop   = sop;
        din_eop   = eop;
        din_data  = data;
        @(negedge clk);
        while (!din_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!din_ready) check("din_ready_timeout", 36'(din_ready), 36'd1);
        @(posedge clk);
        #1;
        din_valid = 1'b0;
        din_sop   = 1'b0;
        din_eop   = 1'b0;
    endtask

    task automatic pulse_cfg(input logic [15:0] w, input logic [15:0] h, input logic [3:0] il);
        cfg_valid      = 1'b1;
        cfg_width      = w;
        cfg_height     = h;
        cfg_interlaced = il;
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
    endtask

    task automatic expect_640x480();
        e(1, 0, 32'h00000F); e(0, 0, 32'h080200); e(0, 0, 32'h010000); e(0, 1, 32'h00000E);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_din_ready",  36'(din_ready),  36'd0);
        check("rst_dout_valid", 36'(dout_valid), 36'd0);
        check("rst_busy",       36'(busy),       36'd0);
        check("rst_ctrl_sent",  36'(ctrl_sent),  36'd0);
        check("rst_ctrl_count", 36'(ctrl_count), 36'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // reset-default configuration is inserted ahead of the first video packet
        expect_640x480();
        e(1, 0, 32'h000000); e(0, 1, 32'h123456);
        drive_beat(1, 0, 24'h000000);
        drive_beat(0, 1, 24'h123456);
        expect_beats("default_cfg", got_a); got_a.delete();
        check("count_default", 36'(ctrl_count), 36'd1);

        // 1920x1080 progressive
        pulse_cfg(16'd1920, 16'd1080, 4'h0);
        e(1, 0, 32'h00000F); e(0, 0, 32'h080700); e(0, 0, 32'h040000); e(0, 1, 32'h000803);
        e(1, 0, 32'h765430); e(0, 0, 32'h0000AB); e(0, 1, 32'h0000CD);
        drive_beat(1, 0, 24'h765430);
        drive_beat(0, 0, 24'h0000AB);
        drive_beat(0, 1, 24'h0000CD);
        expect_beats("cfg_1080p", got_a); got_a.delete();
        check("count_1080p", 36'(ctrl_count), 36'd2);
        check("sent_1080p",  36'(sent_a),     36'd2);

        // clean config: no insertion
        e(1, 0, 32'hFEDCB0); e(0, 1, 32'h13579B);
        drive_beat(1, 0, 24'hFEDCB0);
        drive_beat(0, 1, 24'h13579B);
        expect_beats("no_insert", got_a); got_a.delete();
        check("count_no_insert", 36'(ctrl_count), 36'd2);

        // upstream control packet is swallowed
        valid_cycles_a = 0;
        rdy_cycles_a   = 0;
        drive_beat(1, 0, 24'h00000F);
        drive_beat(0, 0, 24'hAAAAAA);
        drive_beat(0, 0, 24'hBBBBBB);
        drive_beat(0, 1, 24'hCCCCCC);
        expect_beats("drop", got_a); got_a.delete();
        check("drop_ready_beats", 36'(rdy_cycles_a),   36'd4);
        check("drop_no_valid",    36'(valid_cycles_a), 36'd0);
        @(negedge clk);
        check("drop_back_idle", 36'(busy), 36'd0);
        @(posedge clk); #1;

        // user packet passes bit-exact
        e(1, 0, 32'h000003); e(0, 0, 32'h55AA55); e(0, 1, 32'h0F0F0F);
        drive_beat(1, 0, 24'h000003);
        drive_beat(0, 0, 24'h55AA55);
        drive_beat(0, 1, 24'h0F0F0F);
        expect_beats("user_pkt", got_a); got_a.delete();

        // stray non-sop beat in IDLE is discarded
        din_valid = 1'b1; din_sop = 1'b0; din_data = 24'h999990;
        @(negedge clk);
        check("stray_ready", 36'(din_ready),  36'd1);
        check("stray_valid", 36'(dout_valid), 36'd0);
        @(posedge clk); #1 din_valid = 1'b0;
        @(negedge clk);
        check("stray_idle", 36'(busy), 36'd0);
        @(posedge clk); #1;

        // random backpressure, config change while the control payload is in flight
        pulse_cfg(16'd1280, 16'd720, 4'h0);
        rand_ready = 1'b1;
        fork
            drive_beat(1, 1, 24'hABCD00);
            begin : cfg_mid
                int t;
                t = 0;
                do begin
                    @(negedge clk);
                    t++;
                end while (!(dout_valid && dout_sop && dout_ready) && t < 100);
                @(posedge clk); #1;
                pulse_cfg(16'd800, 16'd600, 4'h2);
            end
        join
        e(1, 0, 32'h00000F); e(0, 0, 32'h000500); e(0, 0, 32'h020000); e(0, 1, 32'h00000D);
        e(1, 1, 32'hABCD00);
        expect_beats("old_snapshot", got_a); got_a.delete();
        e(1, 0, 32'h00000F); e(0, 0, 32'h020300); e(0, 0, 32'h020000); e(0, 1, 32'h020805);
        e(1, 1, 32'h000070);
        drive_beat(1, 1, 24'h000070);
        expect_beats("cfg_800x600", got_a); got_a.delete();
        rand_ready = 1'b0;
        dout_ready = 1'b1;
        check("count_random", 36'(ctrl_count), 36'd4);
        check("sent_random",  36'(sent_a),     36'd4);

        // reset while forwarding
        drive_beat(1, 0, 24'h000000);
        din_valid = 1'b1; din_sop = 1'b0; din_eop = 1'b0; din_data = 24'h111110;
        @(negedge clk);
        check("pass_busy",  36'(busy),       36'd1);
        check("pass_valid", 36'(dout_valid), 36'd1);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_valid", 36'(dout_valid), 36'd0);
        check("midrst_busy",  36'(busy),       36'd0);
        check("midrst_count", 36'(ctrl_count), 36'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        din_valid = 1'b0;
        got_a.delete();

        expect_640x480();
        e(1, 1, 32'h0000A0);
        drive_beat(1, 1, 24'h0000A0);
        expect_beats("post_rst", got_a); got_a.delete();
        check("count_post_rst", 36'(ctrl_count), 36'd1);
        check("sent_post_rst",  36'(sent_a),     36'd5);

        // SPB=4 always-insert and SPB=1 instances, two single-beat video packets each
        go_bc = 1'b1;
        repeat (60) @(posedge clk);
        #1;
        check("b_pkts", 36'(pk_b), 36'd2);
        check("c_pkts", 36'(pk_c), 36'd2);
        for (int k = 0; k < 2; k++) begin
            e(1, 0, 32'h0000000F); e(0, 0, 32'h00080200); e(0, 0, 32'h000E0100); e(0, 1, 32'h0);
            e(1, 1, 32'h0);
        end
        if (got_b.size() > 3) check("b_last_sym3", 36'(got_b[3].data[31:24]), 36'd0);
        expect_beats("spb4", got_b);
        check("b_count", 36'(b_ctrl_count), 36'd2);
        begin : spb1_expect
            logic [3:0] nib [9];
            int         first_eop;
            nib = '{4'h0, 4'h2, 4'h8, 4'h0, 4'h0, 4'h1, 4'hE, 4'h0, 4'h0};
            first_eop = -1;
            for (int i = 0; i < got_c.size(); i++) if (first_eop < 0 && got_c[i].eop) first_eop = i;
            check("c_ctrl_beats", 36'(first_eop + 1), 36'd10);
            e(1, 0, 32'h0F);
            for (int i = 0; i < 9; i++) e(0, i == 8, {28'h0, nib[i]});
            e(1, 1, 32'h0); e(1, 1, 32'h0);
        end
        expect_beats("spb1", got_c);
        check("c_count", 36'(c_ctrl_count), 36'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vip_control_packet_inserter.md
Name: vip_control_packet_inserter

Overview:
- Avalon-ST stream sequencer placed upstream of the CVO/frame-reader control packet decoders.
- Filters upstream control packets (type 0xF) and passes user packets (types 0x1–0xE) through unchanged.
- Inserts a locally generated control packet (width/height/interlaced) immediately before a video packet (type 0x0) when configuration changed, or before every video packet in always-insert mode.

Parameters:
- BITS_PER_SYMBOL, 8, symbol width; must be ≥4.
- SYMBOLS_PER_BEAT, 3, symbols per beat; legal values 1..4.
- INSERT_ALWAYS, 0, 1 = insert before every video packet; 0 = insert only when config is dirty.
- DROP_UPSTREAM_CTRL, 1, 1 = discard incoming type-0xF packets; 0 = pass them.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- din_ready  out  1  sink ready
- din_valid  in  1  sink valid
- din_sop  in  1  sink start of packet
- din_eop  in  1  sink end of packet
- din_data  in  BPS*SPB  sink data
- dout_ready  in  1  source ready
- dout_valid  out  1  source valid
- dout_sop  out  1  source start of packet
- dout_eop  out  1  source end of packet
- dout_data  out  BPS*SPB  source data
- cfg_valid  in  1  one-cycle strobe; captures cfg_*
- cfg_width  in  16  field width
- cfg_height  in  16  field height
- cfg_interlaced  in  4  interlace nibble
- busy  out  1  high in any state except IDLE
- ctrl_sent  out  1  one-cycle pulse on the accepted eop beat of an inserted packet
- ctrl_count  out  16  number of inserted packets; wraps at 16 bits

Behaviour:
- Reset values:
  - Streaming outputs: din_ready, dout_valid, dout_sop, dout_eop, dout_data, busy, ctrl_sent = 0.
  - ctrl_count = 0.
  - pending = 640 x 480, interlaced 0.
  - dirty = 1.
  - state = IDLE.
- Reset asserted mid-packet aborts the packet; outputs take reset values the following cycle. The partial packet is not completed.
- Control packet format:
  - Header beat: sop=1; symbol0 low nibble = 0xF; all other bits 0.
  - Payload symbols, in order: w[15:12], w[11:8], w[7:4], w[3:0], h[15:12], h[11:8], h[7:4], h[3:0], interlaced.
  - Each symbol carries its nibble in bits [3:0]; upper bits are 0.
  - Payload is packed symbol0-first (LSB) into N = ceil(9/SPB) beats: SPB=1→9, 2→5, 3→3, 4→3.
  - Unused trailing symbols are 0. The last payload beat has eop=1.
- States:
  - IDLE: din_ready=0, dout_valid=0. When din_valid:
    - !din_sop: stray beat; din_ready=1 for one cycle, beat discarded, stay in IDLE.
    - sop, type 0xF, DROP_UPSTREAM_CTRL=1 → DROP.
    - sop, type 0x0, (INSERT_ALWAYS or dirty) → SEND_HDR. On this transition: snapshot ← pending; dirty ← 0, unless cfg_valid fires in the same cycle, in which case dirty stays 1.
    - Otherwise → PASS.
    - The sop beat is never consumed in IDLE.
  - SEND_HDR: dout_valid=1, header beat from snapshot. On dout_ready → SEND_DATA with beat=0.
  - SEND_DATA: dout_valid=1, payload beat `beat`. On dout_ready: increment beat; at beat N-1 pulse ctrl_sent, increment ctrl_count, → PASS.
  - PASS: combinational feed-through:
    - din_ready = dout_ready; dout_valid = din_valid.
    - dout_sop/eop/data = din_sop/eop/data.
    - On accepted eop → IDLE. A single-beat packet (sop & eop) returns to IDLE after one transfer.
  - DROP: din_ready=1, dout_valid=0. On accepted eop → IDLE.
- Handshake rules:
  - Once dout_valid is raised in a SEND state, the beat holds stable until dout_ready.
  - din is stalled (din_ready=0) throughout SEND states.
- Latency: first dout beat appears one cycle after the sop is presented in IDLE. There is one bubble cycle per packet in IDLE.
- Config capture:
  - cfg_valid sets pending ← cfg_* and dirty ← 1 in any state.
  - An in-flight control packet always uses the snapshot, so mid-insertion updates take effect at the next video packet.

Decomposition:
- Package vip_pkt_pkg:
  - PKT_TYPE_VIDEO=4'h0, PKT_TYPE_CTRL=4'hF.
  - State enum {IDLE, SEND_HDR, SEND_DATA, PASS, DROP}.
  - Function ctrl_payload_beats(spb) returning N.
- Sub-module vip_ctrl_packet_formatter: combinational. Inputs: beat index, snapshot fields. Outputs: payload dout_data and eop for that beat.
- The FSM, counters and config registers stay in the top module.

Test Plan:
- SPB=3, cfg 1920x1080 progressive, then video sop (din_data[3:0]=0) → dout sequence:
  - 24'h00000F (sop)
  - 24'h080700
  - 24'h040000
  - 24'h000803 (eop)
  - then the video packet unchanged; ctrl_sent pulses once; ctrl_count=1.
- Two video packets with no new cfg, INSERT_ALWAYS=0 → second packet passes with no insertion. Same with INSERT_ALWAYS=1 → two inserts, ctrl_count=2.
- Upstream type-0xF packet of 4 beats, DROP=1 → din_ready high for 4 beats, dout_valid stays 0. User packet type 0x3 → forwarded bit-exact.
- dout_ready toggled randomly during SEND_DATA → beats held stable, none skipped or duplicated. cfg_valid 800x600 mid-insertion → current packet carries old values; next video packet gets 0x0320/0x0258.
- After reset, first video packet → control packet carrying 640x480 (0x0280/0x01E0). Reset asserted during PASS → dout_valid=0 next cycle, state IDLE, ctrl_count=0.
- SPB=1 and SPB=4 builds → 10 and 4 beats respectively; for SPB=4 the last beat's symbol3 is 0.
